// File: rtl/psum_pkg.sv
// ============================================================================
// psum_pkg
// Shared definitions for the partial-sum accumulation path.
//   ARRAY_DIM  : lanes per beat (PE array width)
//   ACC_WIDTH  : bits per lane, two's complement
//   ADDR_WIDTH : partial-sum buffer row address width
//   LANE_W     : width of one lane slice
//   VEC_W      : width of one full beat
//   lane_of()  : extract lane idx from a packed beat at the default sizes
// ============================================================================
package psum_pkg;

    localparam int ARRAY_DIM  = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int LANE_W     = ACC_WIDTH;
    localparam int VEC_W      = ARRAY_DIM * ACC_WIDTH;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [VEC_W-1:0]  vec_t;

    function automatic lane_t lane_of(input vec_t vec, input int unsigned idx);
        return vec[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/psum_lane_adder.sv
// ============================================================================
// psum_lane_adder
// Combinational multi-lane adder. Each lane wraps modulo 2^LANE_WIDTH and no
// carry crosses a lane boundary.
// Ports:
//   a    in   LANES*LANE_WIDTH   operand A, lane i = [i*LANE_WIDTH +: LANE_WIDTH]
//   b    in   LANES*LANE_WIDTH   operand B
//   sum  out  LANES*LANE_WIDTH   lane-wise a + b
// ============================================================================
module psum_lane_adder #(
    parameter int LANES      = psum_pkg::ARRAY_DIM,
    parameter int LANE_WIDTH = psum_pkg::LANE_W
) (
    input  logic [LANES*LANE_WIDTH-1:0] a,
    input  logic [LANES*LANE_WIDTH-1:0] b,
    output logic [LANES*LANE_WIDTH-1:0] sum
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Per-lane add truncates to LANE_WIDTH, giving the wrap behaviour.
        assign sum[i*LANE_WIDTH +: LANE_WIDTH] =
            a[i*LANE_WIDTH +: LANE_WIDTH] + b[i*LANE_WIDTH +: LANE_WIDTH];
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// ============================================================================
// psum_accum_ctrl
// Read-modify-write sequencer between the PE array and the partial-sum buffer.
// Each accepted beat reads its buffer row, adds the incoming lanes (or simply
// takes them on a first pass), writes the result back, and on a last pass also
// hands the result to a valid/ready output register. One beat per cycle.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_addr              buffer row of the beat
//   in_data              ARRAY_DIM lanes of ACC_WIDTH partial sums
//   in_first, in_last    ignore stored value / also emit the result
//   buf_raddr            buffer read address (data returns one cycle later)
//   buf_rdata            buffer registered read data
//   buf_waddr/wdata/wen  buffer write port
//   out_valid/out_ready  final-sum handshake
//   out_addr, out_data   row and value of the final sum
//   idle                 nothing in S1 and nothing in the output register
//
// Pipeline: S0 presents the read address and captures the beat into S1.
// S1 combines the beat with buf_rdata (or the forwarded previous result) and
// writes back. A last-pass beat in S1 cannot advance while the output
// register is occupied and not being drained; that is the only stall.
// ============================================================================
module psum_accum_ctrl #(
    parameter int ARRAY_DIM  = psum_pkg::ARRAY_DIM,
    parameter int ACC_WIDTH  = psum_pkg::ACC_WIDTH,
    parameter int ADDR_WIDTH = psum_pkg::ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] in_data,
    input  logic                           in_first,
    input  logic                           in_last,

    output logic [ADDR_WIDTH-1:0]          buf_raddr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_rdata,
    output logic [ADDR_WIDTH-1:0]          buf_waddr,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_wdata,
    output logic                           buf_wen,

    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data,

    output logic                           idle
);

    import psum_pkg::*;

    localparam int DATA_W = ARRAY_DIM * ACC_WIDTH;

    // S1 stage
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_W-1:0]     s1_data;
    logic                  s1_first;
    logic                  s1_last;
    logic                  s1_fwd;

    // Result of the most recent S1 write, for back-to-back same-row beats
    logic [DATA_W-1:0]     fwd_sum;

    logic                  s1_stall;
    logic                  accept;
    logic                  s1_advance;
    logic                  out_load;
    logic [DATA_W-1:0]     operand;
    logic [DATA_W-1:0]     sum;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign s1_stall   = s1_valid & s1_last & out_valid & ~out_ready;
    assign in_ready   = ~s1_stall;
    assign accept     = in_valid & in_ready;
    assign s1_advance = s1_valid & ~s1_stall;
    assign out_load   = s1_advance & s1_last;

    // While stalled, keep reading the S1 row so buf_rdata is still valid for
    // it on the cycle the stall releases.
    assign buf_raddr = s1_stall ? s1_addr : in_addr;

    // ------------------------------------------------------------------
    // Combine
    // ------------------------------------------------------------------
    // The buffer read for a beat is issued while the previous beat is still
    // being written, so a same-row predecessor's result must come from
    // fwd_sum. Anything older has already landed in the buffer.
    always_comb begin
        operand = '0;
        if (!s1_first) begin
            operand = s1_fwd ? fwd_sum : buf_rdata;
        end
    end

    psum_lane_adder #(
        .LANES      (ARRAY_DIM),
        .LANE_WIDTH (ACC_WIDTH)
    ) u_adder (
        .a   (operand),
        .b   (s1_data),
        .sum (sum)
    );

    assign buf_wen   = s1_advance;
    assign buf_waddr = s1_addr;
    assign buf_wdata = sum;

    assign idle = ~s1_valid & ~out_valid;

    // ------------------------------------------------------------------
    // S1, forward and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_fwd    <= 1'b0;
            fwd_sum   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            if (!s1_stall) begin
                s1_valid <= accept;
                s1_fwd   <= accept & s1_advance & (s1_addr == in_addr);
                if (accept) begin
                    s1_addr  <= in_addr;
                    s1_data  <= in_data;
                    s1_first <= in_first;
                    s1_last  <= in_last;
                end
            end

            if (s1_advance) begin
                fwd_sum <= sum;
            end

            // A reload in the same cycle as a drain keeps out_valid high.
            if (out_load) begin
                out_valid <= 1'b1;
                out_addr  <= s1_addr;
                out_data  <= sum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
module tb_psum_accum_ctrl;

    import psum_pkg::*;

    localparam int NL = ARRAY_DIM;
    localparam int LW = ACC_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = VEC_W;
    localparam int NROWS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          in_first;
    logic          in_last;
    logic [AW-1:0] buf_raddr;
    logic [DW-1:0] buf_rdata;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_wdata;
    logic          buf_wen;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          idle;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_wen   (buf_wen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .idle      (idle)
    );

    // Buffer model: registered read (old data on same-edge write), untouched by reset.
    logic [DW-1:0] mem [0:NROWS-1];
    always @(posedge clk) begin
        if (buf_wen) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } item_t;

    item_t         out_q[$];
    item_t         wr_q[$];
    logic [DW-1:0] ref_mem [0:NROWS-1];
    bit            started [0:NROWS-1];
    bit            rand_bp = 1'b0;
    int            total = 0;
    int            bad = 0;

    task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [LW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = v;
        return r;
    endfunction

    // Reference: each lane is an independent 32-bit wrapping accumulator.
    function automatic logic [DW-1:0] acc_model(input logic [DW-1:0] old, input logic [DW-1:0] d, input bit first);
        logic [DW-1:0] r;
        lane_t         base;
        lane_t         s;
        for (int i = 0; i < NL; i++) begin
            base = first ? '0 : lane_of(old, i);
            s = base + lane_of(d, i);
            r[i*LW +: LW] = s;
        end
        return r;
    endfunction

    // Monitor: output handshakes, output stability and buffer writes.
    item_t         mon_e;
    bit            hold = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold) begin
                check_bit("out_hold_valid", out_valid, 1'b1);
                check_vec("out_hold_addr", DW'(out_addr), DW'(hold_addr));
                check_vec("out_hold_data", out_data, hold_data);
            end
            hold = out_valid && !out_ready;
            hold_addr = out_addr;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got addr %0d, expected no output", out_addr);
                end else begin
                    mon_e = out_q.pop_front();
                    check_vec("out_addr", DW'(out_addr), DW'(mon_e.addr));
                    check_vec("out_data", out_data, mon_e.data);
                end
            end
            if (buf_wen) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got write to %0d, expected no write", buf_waddr);
                end else begin
                    mon_e = wr_q.pop_front();
                    check_vec("wr_addr", DW'(buf_waddr), DW'(mon_e.addr));
                    check_vec("wr_data", buf_wdata, mon_e.data);
                end
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit first, input bit last);
        logic [DW-1:0] nv;
        int            waited;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_first = first;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 100 cycles");
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        @(posedge clk);
        nv = acc_model(ref_mem[a], d, first);
        ref_mem[a] = nv;
        started[a] = 1'b1;
        wr_q.push_back('{a, nv});
        if (last) out_q.push_back('{a, nv});
        #1;
        in_valid = 1'b0;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int waited;
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (idle && out_q.size() == 0 && wr_q.size() == 0) break;
            waited++;
            if (waited > 300) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: pending out=%0d wr=%0d, expected 0", out_q.size(), wr_q.size());
                break;
            end
        end
        tick();
    endtask

    logic [DW-1:0] v_idx;
    logic [DW-1:0] v_exp;
    logic [DW-1:0] v_a;
    logic [DW-1:0] v_b;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int unsigned   pick;
    bit            rf;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_buf_wen", buf_wen, 1'b0);
        check_bit("rst_idle", idle, 1'b1);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_vec("rst_out_addr", DW'(out_addr), '0);
        check_vec("rst_out_data", out_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // First then last to row 5 with a gap: 1 + 2 = 3.
        send(10'd5, rep(32'd1), 1'b1, 1'b0);
        tick();
        tick();
        send(10'd5, rep(32'd2), 1'b0, 1'b1);
        drain();
        check_vec("mem5", mem[5], rep(32'd3));

        // Back-to-back to row 7: exercises forwarding, 10 + 20 + 30 = 60.
        send(10'd7, rep(32'd10), 1'b1, 1'b0);
        send(10'd7, rep(32'd20), 1'b0, 1'b0);
        send(10'd7, rep(32'd30), 1'b0, 1'b1);
        drain();
        check_vec("mem7", mem[7], rep(32'd60));

        // Alternating rows 1/2, four passes of lane value i -> 4*i.
        for (int i = 0; i < NL; i++) begin
            v_idx[i*LW +: LW] = LW'(i);
            v_exp[i*LW +: LW] = LW'(4 * i);
        end
        for (int p = 0; p < 4; p++) begin
            send(10'd1, v_idx, p == 0, p == 3);
            send(10'd2, v_idx, p == 0, p == 3);
        end
        drain();
        check_vec("mem1_alt", mem[1], v_exp);
        check_vec("mem2_alt", mem[2], v_exp);

        // Lane wrap and lane isolation.
        v_a = '0;
        v_a[0*LW +: LW]  = 32'h7FFF_FFFF;
        v_a[1*LW +: LW]  = 32'hFFFF_FFFF;
        v_a[15*LW +: LW] = 32'h1234_5678;
        v_b = '0;
        v_b[0*LW +: LW]  = 32'd1;
        v_b[1*LW +: LW]  = 32'd1;
        v_exp = '0;
        v_exp[0*LW +: LW]  = 32'h8000_0000;
        v_exp[15*LW +: LW] = 32'h1234_5678;
        send(10'd3, v_a, 1'b1, 1'b0);
        send(10'd3, v_b, 1'b0, 1'b1);
        drain();
        check_vec("mem3_wrap", mem[3], v_exp);

        // Output backpressure with two last beats queued (first & last together).
        out_ready = 1'b0;
        send(10'd20, rep(32'd4), 1'b1, 1'b1);
        send(10'd21, rep(32'd5), 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_bit("stall_in_ready", in_ready, 1'b0);
            check_bit("stall_buf_wen", buf_wen, 1'b0);
            check_bit("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check_vec("mem20", mem[20], rep(32'd4));
        check_vec("mem21", mem[21], rep(32'd5));

        // Reset with a beat sitting in S1: no write, no output.
        in_valid = 1'b1;
        in_addr  = 10'd5;
        in_data  = rep(32'd9);
        in_first = 1'b1;
        in_last  = 1'b1;
        @(negedge clk);
        check_bit("rstmid_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_bit("rstmid_buf_wen", buf_wen, 1'b0);
        check_bit("rstmid_out_valid", out_valid, 1'b0);
        check_bit("rstmid_idle", idle, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("rstmid_post_wen", buf_wen, 1'b0);
        check_vec("rstmid_mem5", mem[5], rep(32'd3));
        tick();

        // Randomized traffic over a few rows including both address extremes.
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 7);
            ra = (pick == 0) ? '0 : (pick == 1) ? '1 : AW'(40 + pick);
            for (int i = 0; i < NL; i++) rd[i*LW +: LW] = $urandom;
            rf = !started[ra] || ($urandom_range(0, 7) == 0);
            send(ra, rd, rf, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

        for (int a = 0; a < NROWS; a++) begin
            if (started[a]) check_vec("mem_final", mem[a], ref_mem[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
